// File: rtl/serial_adder_seq_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_adder_seq_pkg;

    // Controller states: idle, digit processing, result-valid pulse.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width of the digit counter. It is never narrower than one bit, so a
    // single-digit configuration still has a legal (constant) counter.
    function automatic int digit_cnt_w(input int width, input int digit);
        int n;
        n = width / digit;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_seq_ripple_slice.sv
// DIGIT-bit ripple-carry slice built from full-adder cells.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle by the parent.
module serial_adder_seq_ripple_slice #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             c_i,
    output logic [DIGIT-1:0] s_o,
    output logic             c_o,
    output logic             c_msb_o
);

    logic [DIGIT:0] carry;

    assign carry[0] = c_i;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign c_o     = carry[DIGIT];
    // Carry into the slice MSB; on the final digit this is the carry into
    // bit WIDTH-1, needed for signed overflow.
    assign c_msb_o = carry[DIGIT-1];

endmodule

// File: rtl/serial_adder_seq.sv
// Multi-cycle A+B+cin / A-B, DIGIT bits per clock through one ripple slice.
// Latency: done_o pulses WIDTH/DIGIT cycles after the accepting edge.
// Backpressure: start_i is ignored while busy_o=1 (no queueing).
module serial_adder_seq
    import serial_adder_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic             cin_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] s_o,
    output logic             c_o,
    output logic             ovf_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int             NDIG     = WIDTH / DIGIT;
    localparam int             CW       = digit_cnt_w(WIDTH, DIGIT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(NDIG - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              carry_q, carry_d;
    logic              c_q, c_d;
    logic              ovf_q, ovf_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [DIGIT-1:0]  sl_sum;
    logic              sl_cout;
    logic              sl_cmsb;
    logic [WIDTH-1:0]  sum_ext;
    logic [WIDTH-1:0]  acc_next;

    serial_adder_seq_ripple_slice #(
        .DIGIT(DIGIT)
    ) u_slice (
        .a_i     (a_q[DIGIT-1:0]),
        .b_i     (b_q[DIGIT-1:0]),
        .c_i     (carry_q),
        .s_o     (sl_sum),
        .c_o     (sl_cout),
        .c_msb_o (sl_cmsb)
    );

    // Digit sum enters the result shift register from the MSB side; the
    // zero-extension keeps the shift legal when DIGIT equals WIDTH.
    always_comb begin
        sum_ext              = '0;
        sum_ext[DIGIT-1:0]   = sl_sum;
        acc_next             = (acc_q >> DIGIT) | (sum_ext << (WIDTH - DIGIT));
    end

    // Next-state, operand shifting and result capture.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        s_d     = s_q;
        carry_d = carry_q;
        c_d     = c_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    // Subtraction is A + ~B + 1: invert B and force carry-in.
                    a_d     = a_i;
                    b_d     = b_i ^ {WIDTH{sub_i}};
                    carry_d = sub_i ? 1'b1 : cin_i;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d   = acc_next;
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = sl_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // Visible result changes only here, so s_o/c_o/ovf_o
                    // keep the previous answer throughout the next RUN.
                    s_d     = acc_next;
                    c_d     = sl_cout;
                    ovf_d   = sl_cout ^ sl_cmsb;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            c_q     <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign s_o    = s_q;
    assign c_o    = c_q;
    assign ovf_o  = ovf_q;
    assign busy_o = (state_q == ST_RUN);
    assign done_o = (state_q == ST_DONE);

endmodule
